// File: rtl/f_stage_pc.sv
// f_stage_pc: fetch-stage program counter and F/D pipeline register.
// Holds the current fetch address, loads the next-PC value every cycle and
// captures the fetched instruction into the decode stage, handling stalls,
// exception/eret redirects and delay-slot tagging.
// Optional feature macro: F_ADEL_EN enables the fetch address-error (AdEL)
// check on the PC being advanced into D.

module f_stage_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic [31:0] F_instr,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        D_is_jump,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_bd,
    output logic        D_valid,
    output logic [4:0]  D_exc_code
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] r_fPc;
    logic [31:0] r_dPc;
    logic [31:0] r_dInstr;
    logic        r_dBd;
    logic        r_dValid;

    logic [31:0] w_instrIn;
    logic [4:0]  w_excCodeIn;

`ifdef F_ADEL_EN
    localparam logic [31:0] IM_LO = 32'h0000_3000;
    localparam logic [31:0] IM_HI = 32'h0000_6FFC;

    logic       w_fetchFault;
    logic [4:0] r_dExcCode;

    // A fetch faults when misaligned or outside the instruction memory window;
    // the faulting fetch still travels to D, but as a zero instruction.
    always_comb begin
        w_fetchFault = (r_fPc[1:0] != 2'b00) || (r_fPc < IM_LO) || (r_fPc > IM_HI);
        w_instrIn    = w_fetchFault ? 32'h0 : F_instr;
        w_excCodeIn  = w_fetchFault ? EXC_ADEL : 5'd0;
    end

    // Exception code register follows the same priority as the rest of D.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dExcCode <= 5'd0;
        end else if (exc_req || eret_req) begin
            r_dExcCode <= 5'd0;
        end else if (!stall) begin
            r_dExcCode <= w_excCodeIn;
        end
    end

    assign D_exc_code = r_dExcCode;
`else
    // Without the address check every fetched word passes straight through.
    always_comb begin
        w_instrIn   = F_instr;
        w_excCodeIn = 5'd0;
    end

    assign D_exc_code = w_excCodeIn;
`endif

    // PC and D-stage registers: reset beats exception, which beats eret,
    // which beats stall; redirects flush D to a bubble carrying the new PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fPc    <= RESET_PC;
            r_dPc    <= 32'h0;
            r_dInstr <= 32'h0;
            r_dBd    <= 1'b0;
            r_dValid <= 1'b0;
        end else if (exc_req) begin
            r_fPc    <= HANDLER_PC;
            r_dPc    <= HANDLER_PC;
            r_dInstr <= 32'h0;
            r_dBd    <= 1'b0;
            r_dValid <= 1'b0;
        end else if (eret_req) begin
            r_fPc    <= epc;
            r_dPc    <= epc;
            r_dInstr <= 32'h0;
            r_dBd    <= 1'b0;
            r_dValid <= 1'b0;
        end else if (!stall) begin
            r_fPc    <= npc;
            r_dPc    <= r_fPc;
            r_dInstr <= w_instrIn;
            r_dBd    <= D_is_jump;
            r_dValid <= 1'b1;
        end
    end

    assign F_pc    = r_fPc;
    assign D_pc    = r_dPc;
    assign D_instr = r_dInstr;
    assign D_bd    = r_dBd;
    assign D_valid = r_dValid;

endmodule
